coeff_load_sequencer: RTL and testbench
=======================================

COEFF_LOAD_SEQUENCER -- requirements
Module: coeff_load_sequencer

Interface
REQ-001 Parameter NUM_TAPS, default 33, number of coefficients per load (legal range 1..62).
REQ-002 Parameter BASE_ADDR, default 2, RAM address of coefficient 0 (BASE_ADDR+NUM_TAPS-1 SHALL be <= 63).
REQ-003 Parameter DATA_W, default 16, coefficient width.
REQ-004 iClk_12M  in  1  sole clock; all state updates on its rising edge.
REQ-005 iRst  in  1  asynchronous, active-high reset.
REQ-006 iStart  in  1  level sampled in IDLE; starts one load sequence.
REQ-007 iAbort  in  1  cancels an in-progress sequence.
REQ-008 iCoeffValid  in  1  upstream coefficient valid.
REQ-009 iCoeffData  in  DATA_W  signed coefficient; ignored unless iCoeffValid.
REQ-010 oCoeffReady  out  1  block accepts a coefficient this cycle.
REQ-011 oCoeffiUpdateFlag  out  1  high while a sequence owns the coefficient RAM bus.
REQ-012 oCsnRam  out  1  RAM chip select, active-low.
REQ-013 oWrnRam  out  1  RAM write strobe, 0 = write, 1 = read.
REQ-014 oAddrRam  out  6  RAM address.
REQ-015 oWrDtRam  out  DATA_W  RAM write data.
REQ-016 oBusy  out  1  high in WRITE or READ.
REQ-017 oDone  out  1  one-cycle pulse on successful sequence completion.

Function
REQ-018 The block SHALL implement FSM states IDLE, WRITE, READ, DONE with a tap index counter idx (0..NUM_TAPS-1).
REQ-019 IDLE: iStart=1 and iAbort=0 -> WRITE with idx=0; iStart while not IDLE SHALL be ignored.
REQ-020 WRITE: oCoeffReady=1; a handshake is iCoeffValid&&oCoeffReady; each handshake increments idx; handshake at idx=NUM_TAPS-1 -> READ with idx=0.
REQ-021 All RAM bus outputs SHALL be registered: handshake at idx=k in cycle n -> cycle n+1 shows oCsnRam=0, oWrnRam=0, oAddrRam=BASE_ADDR+k, oWrDtRam=iCoeffData captured at n.
REQ-022 WRITE cycles without handshake (valid low) SHALL drive oCsnRam=1, oWrnRam=1; oAddrRam/oWrDtRam hold last values; sequence stalls indefinitely without timeout.
REQ-023 READ: oCoeffReady=0; for idx=0..NUM_TAPS-1 on consecutive cycles the next-cycle bus SHALL be oCsnRam=0, oWrnRam=1, oAddrRam=BASE_ADDR+idx, oWrDtRam held; after idx=NUM_TAPS-1 -> DONE.
REQ-024 DONE: lasts exactly one cycle, oDone=1, bus idle (oCsnRam=1, oWrnRam=1), then IDLE.
REQ-025 oCoeffiUpdateFlag SHALL be registered high from the first cycle after entering WRITE through the last READ bus cycle, low in DONE and IDLE.
REQ-026 Write sequence + read-back SHALL total exactly NUM_TAPS bus-write cycles plus NUM_TAPS back-to-back bus-read cycles; no address outside BASE_ADDR..BASE_ADDR+NUM_TAPS-1 SHALL be driven with oCsnRam=0.
REQ-027 iAbort=1 in WRITE or READ SHALL return to IDLE next cycle; bus idle and oCoeffiUpdateFlag=0 from that cycle; no oDone; coefficient offered in the abort cycle SHALL NOT be accepted (oCoeffReady combinationally low when iAbort=1).
REQ-028 iAbort in IDLE or DONE SHALL have no effect beyond blocking a same-cycle iStart.
REQ-029 Address arithmetic SHALL be 6-bit unsigned; no wrap can occur under legal parameters.

Reset
REQ-030 While iRst=1 (asynchronous assertion): state=IDLE, idx=0, oCsnRam=1, oWrnRam=1, oAddrRam=0, oWrDtRam=0, oCoeffiUpdateFlag=0, oCoeffReady=0, oBusy=0, oDone=0.
REQ-031 Reset mid-sequence SHALL discard progress; a new iStart after deassertion SHALL restart at idx=0.

Verification
REQ-032 Default params, iStart pulse, 33 coefficients 0x0001..0x0021 with valid held high -> writes addr 2..34 data 0x0001..0x0021 on 33 consecutive cycles, then 33 reads addr 2..34, oDone one cycle, total 1+33+33+1 cycles.
REQ-033 Valid deasserted 3 cycles after coefficient 10 -> 3 idle bus cycles (csn=1), coefficient 11 written to addr 13 afterward; no lost or duplicated data.
REQ-034 iAbort at coefficient 5 in WRITE -> no write to addr 7, flag low next cycle, no oDone; fresh iStart then writes from addr 2.
REQ-035 iAbort during READ at addr 20 -> bus idle next cycle, no oDone.
REQ-036 iRst asserted during READ at addr 15 -> outputs at reset values immediately, state IDLE.
REQ-037 iStart held high in READ and iStart+iAbort together in IDLE -> both ignored; single oDone per sequence.

Source files
------------

// File: rtl/coeff_load_sequencer_if.sv
// rtl/coeff_load_sequencer_if.sv - coefficient stream and RAM bus bundle for coeff_load_sequencer
interface coeff_load_sequencer_if #(
    parameter int DATA_W = 16
) ();
    logic                     iCoeffValid;
    logic signed [DATA_W-1:0] iCoeffData;
    logic                     oCoeffReady;
    logic                     oCoeffiUpdateFlag;
    logic                     oCsnRam;
    logic                     oWrnRam;
    logic [5:0]               oAddrRam;
    logic [DATA_W-1:0]        oWrDtRam;

    modport master (
        input  iCoeffValid,
        input  iCoeffData,
        output oCoeffReady,
        output oCoeffiUpdateFlag,
        output oCsnRam,
        output oWrnRam,
        output oAddrRam,
        output oWrDtRam
    );

    modport slave (
        output iCoeffValid,
        output iCoeffData,
        input  oCoeffReady,
        input  oCoeffiUpdateFlag,
        input  oCsnRam,
        input  oWrnRam,
        input  oAddrRam,
        input  oWrDtRam
    );
endinterface

// File: rtl/coeff_load_sequencer.sv
// rtl/coeff_load_sequencer.sv - writes NUM_TAPS streamed coefficients into RAM, then reads them all back
module coeff_load_sequencer #(
    parameter int NUM_TAPS  = 33,
    parameter int BASE_ADDR = 2,
    parameter int DATA_W    = 16
) (
    input  logic                    iClk_12M,
    input  logic                    iRst,
    input  logic                    iStart,
    input  logic                    iAbort,
    output logic                    oBusy,
    output logic                    oDone,
    coeff_load_sequencer_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [5:0] LAST_IDX = 6'(NUM_TAPS - 1);
    localparam logic [5:0] BASE     = 6'(BASE_ADDR);

    state_t     state;
    state_t     nextState;
    logic [5:0] idx;
    logic [5:0] nextIdx;
    logic       coeffReady;
    logic       busWrite;
    logic       busRead;

    always_ff @(posedge iClk_12M or posedge iRst) begin
        if (iRst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= nextState;
            idx   <= nextIdx;
        end
    end

    // Abort wins over everything in WRITE/READ, including the handshake of the same cycle.
    always_comb begin
        nextState  = state;
        nextIdx    = idx;
        coeffReady = 1'b0;
        case (state)
            IDLE: begin
                if (iStart && !iAbort) begin
                    nextState = WRITE;
                    nextIdx   = '0;
                end
            end
            WRITE: begin
                if (iAbort) begin
                    nextState = IDLE;
                    nextIdx   = '0;
                end else begin
                    coeffReady = 1'b1;
                    if (bus.iCoeffValid) begin
                        if (idx == LAST_IDX) begin
                            nextState = READ;
                            nextIdx   = '0;
                        end else begin
                            nextIdx = idx + 6'd1;
                        end
                    end
                end
            end
            READ: begin
                if (iAbort) begin
                    nextState = IDLE;
                    nextIdx   = '0;
                end else if (idx == LAST_IDX) begin
                    nextState = DONE;
                    nextIdx   = '0;
                end else begin
                    nextIdx = idx + 6'd1;
                end
            end
            DONE: begin
                nextState = IDLE;
                nextIdx   = '0;
            end
            default: begin
                nextState = IDLE;
                nextIdx   = '0;
            end
        endcase
    end

    assign bus.oCoeffReady = coeffReady;
    assign busWrite        = coeffReady && bus.iCoeffValid;
    assign busRead         = (state == READ) && !iAbort;
    assign oBusy           = (state == WRITE) || (state == READ);

    // Bus outputs lag the FSM by one cycle; address and data hold during stalls.
    always_ff @(posedge iClk_12M or posedge iRst) begin
        if (iRst) begin
            bus.oCsnRam           <= 1'b1;
            bus.oWrnRam           <= 1'b1;
            bus.oAddrRam          <= '0;
            bus.oWrDtRam          <= '0;
            bus.oCoeffiUpdateFlag <= 1'b0;
            oDone                 <= 1'b0;
        end else begin
            bus.oCsnRam           <= !(busWrite || busRead);
            bus.oWrnRam           <= !busWrite;
            if (busWrite || busRead) begin
                bus.oAddrRam <= BASE + idx;
            end
            if (busWrite) begin
                bus.oWrDtRam <= bus.iCoeffData;
            end
            bus.oCoeffiUpdateFlag <= oBusy && !iAbort;
            oDone                 <= (state == DONE);
        end
    end

endmodule

// File: tb/tb_coeff_load_sequencer.sv
// tb/tb_coeff_load_sequencer.sv - directed self-checking bench for coeff_load_sequencer
module tb_coeff_load_sequencer;
    localparam int NUM_TAPS  = 33;
    localparam int BASE_ADDR = 2;
    localparam int DATA_W    = 16;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic busy;
    logic done;

    coeff_load_sequencer_if #(.DATA_W(DATA_W)) bus ();

    coeff_load_sequencer #(
        .NUM_TAPS (NUM_TAPS),
        .BASE_ADDR(BASE_ADDR),
        .DATA_W   (DATA_W)
    ) dut (
        .iClk_12M(clk),
        .iRst    (rst),
        .iStart  (start),
        .iAbort  (abort),
        .oBusy   (busy),
        .oDone   (done),
        .bus     (bus.master)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    int wrCnt    = 0;
    int rdCnt    = 0;
    int doneCnt  = 0;
    int badAddr  = 0;
    int wrHits [64];
    logic [DATA_W-1:0] wrData [64];

    initial begin
        for (int a = 0; a < 64; a++) begin
            wrHits[a] = 0;
            wrData[a] = '0;
        end
    end

    always @(negedge clk) begin
        if (!bus.oCsnRam) begin
            if (bus.oAddrRam < 6'(BASE_ADDR) || bus.oAddrRam > 6'(BASE_ADDR + NUM_TAPS - 1))
                badAddr <= badAddr + 1;
            if (!bus.oWrnRam) begin
                wrCnt                 <= wrCnt + 1;
                wrHits[bus.oAddrRam]  <= wrHits[bus.oAddrRam] + 1;
                wrData[bus.oAddrRam]  <= bus.oWrDtRam;
            end else begin
                rdCnt <= rdCnt + 1;
            end
        end
        if (done) doneCnt <= doneCnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_seq();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            bus.iCoeffValid = 1'b1;
            bus.iCoeffData  = DATA_W'(first + i + 1);
            tick();
        end
        bus.iCoeffValid = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] got;
        tick();
        got = {bus.oCsnRam, bus.oWrnRam, bus.oAddrRam, bus.oWrDtRam, bus.oCoeffiUpdateFlag,
               bus.oCoeffReady, busy, done};
        checks++;
        if (got !== {1'b1, 1'b1, 6'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_outputs: got %h expected %h", got,
                     {1'b1, 1'b1, 6'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0});
        end
        rst = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || bus.oCsnRam !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_idle: busy=%b csn=%b expected busy=0 csn=1", busy, bus.oCsnRam);
        end
    endtask

    task automatic test_full_sequence();
        logic [24:0] got;
        logic [24:0] exp;
        int d0 = doneCnt;
        start_seq();
        checks++;
        if (bus.oCoeffReady !== 1'b1 || busy !== 1'b1 || bus.oCoeffiUpdateFlag !== 1'b0) begin
            failures++;
            $display("FAIL write_entry: ready=%b busy=%b flag=%b expected 1 1 0",
                     bus.oCoeffReady, busy, bus.oCoeffiUpdateFlag);
        end
        for (int k = 0; k < NUM_TAPS; k++) begin
            bus.iCoeffValid = 1'b1;
            bus.iCoeffData  = DATA_W'(k + 1);
            tick();
            got = {bus.oCsnRam, bus.oWrnRam, bus.oAddrRam, bus.oWrDtRam, bus.oCoeffiUpdateFlag};
            exp = {1'b0, 1'b0, 6'(BASE_ADDR + k), 16'(k + 1), 1'b1};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL full_write_%0d: got %h expected %h", k, got, exp);
            end
        end
        bus.iCoeffValid = 1'b0;
        checks++;
        if (bus.oCoeffReady !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL read_entry: ready=%b busy=%b expected 0 1", bus.oCoeffReady, busy);
        end
        for (int r = 0; r < NUM_TAPS; r++) begin
            tick();
            got = {bus.oCsnRam, bus.oWrnRam, bus.oAddrRam, bus.oWrDtRam, bus.oCoeffiUpdateFlag};
            exp = {1'b0, 1'b1, 6'(BASE_ADDR + r), 16'h0021, 1'b1};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL full_read_%0d: got %h expected %h", r, got, exp);
            end
        end
        tick();
        checks++;
        if ({done, bus.oCsnRam, bus.oWrnRam, bus.oCoeffiUpdateFlag, busy} !== 5'b11100) begin
            failures++;
            $display("FAIL done_cycle: done/csn/wrn/flag/busy=%b expected 11100",
                     {done, bus.oCsnRam, bus.oWrnRam, bus.oCoeffiUpdateFlag, busy});
        end
        tick();
        checks++;
        if (done !== 1'b0 || doneCnt - d0 != 1) begin
            failures++;
            $display("FAIL done_single_pulse: done=%b pulses=%0d expected 0 and 1", done, doneCnt - d0);
        end
    endtask

    task automatic test_stall();
        int w0 = wrCnt;
        int r0 = rdCnt;
        int d0 = doneCnt;
        int bad = 0;
        start_seq();
        feed(0, 11);
        for (int s = 0; s < 3; s++) begin
            tick();
            checks++;
            if ({bus.oCsnRam, bus.oWrnRam, bus.oAddrRam, bus.oWrDtRam} !== {1'b1, 1'b1, 6'd12, 16'd11}) begin
                failures++;
                $display("FAIL stall_idle_%0d: got %h expected %h", s,
                         {bus.oCsnRam, bus.oWrnRam, bus.oAddrRam, bus.oWrDtRam}, {1'b1, 1'b1, 6'd12, 16'd11});
            end
        end
        feed(11, 1);
        checks++;
        if ({bus.oCsnRam, bus.oWrnRam, bus.oAddrRam, bus.oWrDtRam} !== {1'b0, 1'b0, 6'd13, 16'd12}) begin
            failures++;
            $display("FAIL stall_resume: got %h expected %h",
                     {bus.oCsnRam, bus.oWrnRam, bus.oAddrRam, bus.oWrDtRam}, {1'b0, 1'b0, 6'd13, 16'd12});
        end
        feed(12, NUM_TAPS - 12);
        repeat (NUM_TAPS + 2) tick();
        checks++;
        if (wrCnt - w0 != NUM_TAPS || rdCnt - r0 != NUM_TAPS || doneCnt - d0 != 1) begin
            failures++;
            $display("FAIL stall_counts: writes=%0d reads=%0d dones=%0d expected 33 33 1",
                     wrCnt - w0, rdCnt - r0, doneCnt - d0);
        end
        for (int a = BASE_ADDR; a < BASE_ADDR + NUM_TAPS; a++)
            if (wrData[a] !== DATA_W'(a - BASE_ADDR + 1)) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL stall_data: wrong addresses=%0d expected 0", bad);
        end
    endtask

    task automatic test_abort_write();
        int h7 = wrHits[7];
        int w0 = wrCnt;
        int d0 = doneCnt;
        start_seq();
        feed(0, 5);
        bus.iCoeffValid = 1'b1;
        bus.iCoeffData  = 16'd6;
        abort           = 1'b1;
        #1;
        checks++;
        if (bus.oCoeffReady !== 1'b0) begin
            failures++;
            $display("FAIL abort_ready_low: got %b expected 0", bus.oCoeffReady);
        end
        tick();
        abort           = 1'b0;
        bus.iCoeffValid = 1'b0;
        checks++;
        if ({bus.oCsnRam, bus.oCoeffiUpdateFlag, busy} !== 3'b100) begin
            failures++;
            $display("FAIL abort_write_idle: csn/flag/busy=%b expected 100",
                     {bus.oCsnRam, bus.oCoeffiUpdateFlag, busy});
        end
        repeat (3) tick();
        checks++;
        if (wrHits[7] != h7 || wrCnt - w0 != 5 || doneCnt != d0) begin
            failures++;
            $display("FAIL abort_write_effects: addr7=%0d writes=%0d dones=%0d expected 0 5 0",
                     wrHits[7] - h7, wrCnt - w0, doneCnt - d0);
        end
        start_seq();
        feed(0, 1);
        checks++;
        if ({bus.oCsnRam, bus.oWrnRam, bus.oAddrRam, bus.oWrDtRam} !== {1'b0, 1'b0, 6'd2, 16'd1}) begin
            failures++;
            $display("FAIL abort_restart: got %h expected %h",
                     {bus.oCsnRam, bus.oWrnRam, bus.oAddrRam, bus.oWrDtRam}, {1'b0, 1'b0, 6'd2, 16'd1});
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
    endtask

    task automatic test_abort_read();
        int r0;
        int d0 = doneCnt;
        start_seq();
        feed(0, NUM_TAPS);
        r0 = rdCnt;
        for (int r = 0; r < 19; r++) tick();
        checks++;
        if ({bus.oCsnRam, bus.oWrnRam, bus.oAddrRam} !== {1'b0, 1'b1, 6'd20}) begin
            failures++;
            $display("FAIL abort_read_at20: got %h expected %h",
                     {bus.oCsnRam, bus.oWrnRam, bus.oAddrRam}, {1'b0, 1'b1, 6'd20});
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if ({bus.oCsnRam, bus.oCoeffiUpdateFlag, busy} !== 3'b100) begin
            failures++;
            $display("FAIL abort_read_idle: csn/flag/busy=%b expected 100",
                     {bus.oCsnRam, bus.oCoeffiUpdateFlag, busy});
        end
        repeat (3) tick();
        checks++;
        if (doneCnt != d0 || rdCnt - r0 != 19) begin
            failures++;
            $display("FAIL abort_read_effects: dones=%0d reads=%0d expected 0 19", doneCnt - d0, rdCnt - r0);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] got;
        start_seq();
        feed(0, NUM_TAPS);
        for (int r = 0; r < 14; r++) tick();
        checks++;
        if ({bus.oCsnRam, bus.oWrnRam, bus.oAddrRam} !== {1'b0, 1'b1, 6'd15}) begin
            failures++;
            $display("FAIL reset_mid_at15: got %h expected %h",
                     {bus.oCsnRam, bus.oWrnRam, bus.oAddrRam}, {1'b0, 1'b1, 6'd15});
        end
        #2 rst = 1'b1;
        #1;
        got = {bus.oCsnRam, bus.oWrnRam, bus.oAddrRam, bus.oWrDtRam, bus.oCoeffiUpdateFlag,
               bus.oCoeffReady, busy, done};
        checks++;
        if (got !== {1'b1, 1'b1, 6'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_mid_async: got %h expected %h", got,
                     {1'b1, 1'b1, 6'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0});
        end
        #2 rst = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || bus.oCsnRam !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_idle: busy=%b csn=%b expected 0 1", busy, bus.oCsnRam);
        end
        start_seq();
        feed(0, 1);
        checks++;
        if ({bus.oCsnRam, bus.oWrnRam, bus.oAddrRam, bus.oWrDtRam} !== {1'b0, 1'b0, 6'd2, 16'd1}) begin
            failures++;
            $display("FAIL reset_mid_restart: got %h expected %h",
                     {bus.oCsnRam, bus.oWrnRam, bus.oAddrRam, bus.oWrDtRam}, {1'b0, 1'b0, 6'd2, 16'd1});
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
    endtask

    task automatic test_start_ignored();
        int d0;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || bus.oCsnRam !== 1'b1) begin
            failures++;
            $display("FAIL start_abort_idle: busy=%b csn=%b expected 0 1", busy, bus.oCsnRam);
        end
        d0 = doneCnt;
        start_seq();
        feed(0, NUM_TAPS);
        start = 1'b1;
        repeat (NUM_TAPS - 1) tick();
        checks++;
        if ({bus.oCsnRam, bus.oWrnRam, bus.oAddrRam} !== {1'b0, 1'b1, 6'd33}) begin
            failures++;
            $display("FAIL start_held_read: got %h expected %h",
                     {bus.oCsnRam, bus.oWrnRam, bus.oAddrRam}, {1'b0, 1'b1, 6'd33});
        end
        tick();
        start = 1'b0;
        repeat (3) tick();
        checks++;
        if (doneCnt - d0 != 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL start_held_done: dones=%0d busy=%b expected 1 0", doneCnt - d0, busy);
        end
    endtask

    task automatic test_address_range();
        checks++;
        if (badAddr != 0) begin
            failures++;
            $display("FAIL address_range: out-of-range selects=%0d expected 0", badAddr);
        end
    endtask

    initial begin
        bus.iCoeffValid = 1'b0;
        bus.iCoeffData  = '0;
        test_reset();
        test_full_sequence();
        test_stall();
        test_abort_write();
        test_abort_read();
        test_reset_mid();
        test_start_ignored();
        test_address_range();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
